// File: rtl/dp_ram_be_clr.sv
// dp_ram_be_clr: single-clock true dual-port RAM with byte enables, 1/2-cycle read latency
// and a clear engine that walks every word to INIT_VAL after reset or on request.
module dp_ram_be_clr #(
    parameter int BYTES = 4,
    parameter int WORDS = 256,
    parameter int LAT = 1,
    parameter int RDW_MODE = 0,
    parameter int CLR_ON_RST = 1,
    parameter logic [8*BYTES-1:0] INIT_VAL = '0,
    localparam int DW = 8*BYTES,
    localparam int AW = $clog2(WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    output logic             busy_o,
    input  logic             a_en_i,
    input  logic [BYTES-1:0] a_we_i,
    input  logic [AW-1:0]    a_addr_i,
    input  logic [DW-1:0]    a_din_i,
    output logic [DW-1:0]    a_dout_o,
    output logic             a_vld_o,
    input  logic             b_en_i,
    input  logic [BYTES-1:0] b_we_i,
    input  logic [AW-1:0]    b_addr_i,
    input  logic [DW-1:0]    b_din_i,
    output logic [DW-1:0]    b_dout_o,
    output logic             b_vld_o
);
    typedef enum logic {IDLE, CLEAR} state_e;

    state_e                   state_q, state_d;
    logic [AW-1:0]            cnt_q, cnt_d;
    logic                     pend_q;
    logic [DW-1:0]            mem [WORDS];
    logic [1:0]               en, act, ok, v1_q, vld;
    logic [1:0][BYTES-1:0]    we;
    logic [1:0][AW-1:0]       addr;
    logic [1:0][DW-1:0]       din, rdata_d, d1_q, dout;

    assign en     = {b_en_i, a_en_i};
    assign we     = {b_we_i, a_we_i};
    assign addr   = {b_addr_i, a_addr_i};
    assign din    = {b_din_i, a_din_i};
    assign busy_o = state_q == CLEAR;
    assign act    = en & {2{~busy_o}};

    for (genvar p = 0; p < 2; p++) begin : g_ok
        assign ok[p] = {1'b0, addr[p]} < (AW+1)'(WORDS);
    end

    // pend_q turns "reset just released" into a one-shot clear request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr_i || pend_q) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else if (state_q == CLEAR) begin
            state_d = (cnt_q == AW'(WORDS-1)) ? IDLE : CLEAR;
            cnt_d   = cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= (CLR_ON_RST != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= 1'b0;
        end
    end

    always_comb begin
        rdata_d = '0;
        for (int p = 0; p < 2; p++) begin
            if (ok[p]) rdata_d[p] = mem[addr[p]];
            for (int k = 0; k < BYTES; k++)
                if (RDW_MODE != 0 && ok[p] && we[p][k]) rdata_d[p][8*k+:8] = din[p][8*k+:8];
        end
    end

    // port B is applied before port A so A wins bytes both ports enable
    always_ff @(posedge clk_i) begin
        if (busy_o) mem[cnt_q] <= INIT_VAL;
        else
            for (int p = 1; p >= 0; p--)
                for (int k = 0; k < BYTES; k++)
                    if (act[p] && ok[p] && we[p][k]) mem[addr[p]][8*k+:8] <= din[p][8*k+:8];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q <= '0;
            d1_q <= '0;
        end else begin
            v1_q <= act;
            for (int p = 0; p < 2; p++)
                if (act[p]) d1_q[p] <= rdata_d[p];
        end
    end

    if (LAT == 2) begin : g_lat2
        logic [1:0]         v2_q;
        logic [1:0][DW-1:0] d2_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v2_q <= '0;
                d2_q <= '0;
            end else begin
                v2_q <= v1_q;
                for (int p = 0; p < 2; p++)
                    if (v1_q[p]) d2_q[p] <= d1_q[p];
            end
        end
        assign vld  = v2_q;
        assign dout = d2_q;
    end else begin : g_lat1
        assign vld  = v1_q;
        assign dout = d1_q;
    end

    assign a_dout_o = dout[0];
    assign b_dout_o = dout[1];
    assign a_vld_o  = vld[0];
    assign b_vld_o  = vld[1];
endmodule

// File: doc/dp_ram_be_clr.md
Name: dp_ram_be_clr

Overview:
- Single-clock true dual-port RAM with per-byte write enables and a selectable read-during-write mode.
- Configurable read latency of 1 or 2 cycles, with an output valid strobe per port.
- Built-in clear engine initialises every word to INIT_VAL after reset or on request.
- Used as the general-purpose buffer for datapath blocks that need two independent access ports and deterministic content after reset.

Parameters:
BYTES, 4, data width in bytes; DW = 8*BYTES.
WORDS, 256, memory depth; AW = $clog2(WORDS).
LAT, 1, read latency in cycles; only 1 or 2 legal.
RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data).
CLR_ON_RST, 1, 1 = clear engine starts automatically when reset releases.
INIT_VAL, 0, DW-bit value written to every word by the clear engine.

Ports:
clk  in  1  clock, all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  single-cycle pulse that starts or restarts a clear.
busy  out  1  high while the clear engine owns the memory.
a_en  in  1  port A access enable.
a_we  in  BYTES  port A byte write enables; they take effect only when a_en=1.
a_addr  in  AW  port A address.
a_din  in  DW  port A write data.
a_dout  out  DW  port A read data.
a_vld  out  1  port A read data valid, one-cycle strobe.
b_en, b_we, b_addr, b_din, b_dout, b_vld: same as port A, for port B.

Behaviour:
- Reset (rst_n=0):
  - a_dout, b_dout, a_vld, b_vld, busy and the clear counter go to 0, including the LAT=2 pipeline stages.
  - RAM array is not reset.
- Reset release:
  - CLR_ON_RST=1: busy=1 on the first clk edge after release and the clear starts at word 0.
  - CLR_ON_RST=0: busy stays 0.
- Reset asserted mid-clear aborts the clear. Content is then partially cleared. It is re-cleared only if CLR_ON_RST=1 or clr is pulsed.
- Clear engine:
  - Two states, IDLE and CLEAR.
  - IDLE -> CLEAR on clr=1: the counter loads 0 and busy=1 from the next cycle.
  - In CLEAR, one word per cycle: ram[cnt] <= INIT_VAL, cnt++.
  - After writing word WORDS-1 -> IDLE, and busy=0 the following cycle. Clear takes exactly WORDS cycles of busy=1.
  - clr=1 while busy: the counter restarts at 0, so busy is extended.
- While busy=1:
  - User writes on both ports are dropped.
  - User reads are dropped: no vld is produced, and dout holds its value.
- Read:
  - a_en=1 in cycle N (with or without write) gives a_dout updated and a_vld=1 in cycle N+LAT.
  - a_vld is 0 in all other cycles.
  - a_dout holds its last value when there is no read.
  - With LAT=2 the second stage is a plain register; back-to-back reads give one result per cycle.
- Write: for each byte k with a_we[k]=1, ram[a_addr][8k+7:8k] <= a_din[8k+7:8k]. Other bytes are unchanged.
- Same-port read-during-write:
  - RDW_MODE=0: dout = pre-write word.
  - RDW_MODE=1: dout = pre-write word with the enabled bytes replaced by din.
- Cross-port, same address, same cycle:
  - Reader port always sees old data.
  - If both ports write: port A wins on bytes enabled by both; bytes enabled only by B take B's data.
- Port B behaviour is identical to port A; the two ports are fully independent apart from the collision rule above.
- Out-of-range addresses (WORDS not a power of 2): writes are ignored, reads return 0.

Test Plan:
- Reset then CLR_ON_RST=1, WORDS=256 -> busy high for exactly 256 cycles. Afterwards, reading addresses 0, 128 and 255 on port B returns INIT_VAL with b_vld exactly LAT cycles after b_en.
- Port A write to 0x10: a_din=0x11223344, a_we=4'b1111. Then a_we=4'b0101, a_din=0xAABBCCDD. Read -> 0x11BB33DD.
- RDW test: ram[5]=0x01020304, then port A writes 0xFFFFFFFF with a_en=1 to addr 5. RDW_MODE=0 -> a_dout=0x01020304; RDW_MODE=1 -> 0xFFFFFFFF. Port B reading addr 5 in the same cycle -> 0x01020304 in both modes.
- Dual write collision at addr 7: A we=4'b0011 din=0xAAAAAAAA, B we=4'b0110 din=0xBBBBBBBB, prior content 0. Read -> 0x00BBAAAA.
- clr pulsed at cycle 100 of a running clear (WORDS=256) -> busy remains high 256 cycles after the re-pulse. User writes issued during busy are absent afterwards, and no a_vld occurs during busy.
- LAT=2 back-to-back reads of addresses 0..7 (pre-loaded with their own index) -> a_vld high for 8 consecutive cycles starting 2 cycles after the first a_en, data 0..7 in order. rst_n low mid-stream -> a_vld and a_dout go to 0 immediately (asynchronous).
